logic_result_checker_8_bits: RTL and testbench
==============================================

// Module: logic_result_checker_8_bits
// PURPOSE
//  Hardware result checker: the consuming/checking end of the 8-bit logic-unit
//  stimulus flow. Accepts (result, expected) pairs from a DUT-side producer over
//  a valid/ready handshake, compares them bit-exactly and tallies a test run of
//  NUM_SCENARIOS scenarios. Reports pass/fail, fail count and first-failure data.
//  Used after not/and/or 8-bit structure units for on-chip self-test.
// PARAMETERS
//  WIDTH          8   data width of result/expected
//  NUM_SCENARIOS  4   transfers per run (1..2**CNT_W-1)
//  CNT_W          8   width of scenario/fail counters and index
// PORTS
//  clk                  in   1      single clock, rising edge
//  reset                in   1      synchronous, active-high
//  start                in   1      begin run (honoured in IDLE and DONE only)
//  in_valid             in   1      producer has a pair
//  in_ready             out  1      checker accepts; 1 only in RUN
//  in_result            in   WIDTH  DUT output
//  in_expected          in   WIDTH  golden value
//  busy                 out  1      1 in RUN
//  done                 out  1      1 in DONE (level, held)
//  pass                 out  1      valid when done; 1 = zero mismatches
//  mismatch             out  1      1-cycle pulse, cycle after a failing accept
//  mismatch_bits        out  WIDTH  result^expected of last accepted pair
//  scenario_count       out  CNT_W  accepted transfers this run
//  fail_count           out  CNT_W  failing transfers, saturates at all-ones
//  first_fail_index     out  CNT_W  1-based scenario no. of first failure, 0=none
//  first_fail_result    out  WIDTH  in_result of first failure
//  first_fail_expected  out  WIDTH  in_expected of first failure
// BEHAVIOUR
//  Reset (sync, any state, mid-run included): state=IDLE; all outputs 0.
//  FSM IDLE -> RUN on start; RUN -> DONE on accept of scenario NUM_SCENARIOS;
//   DONE -> RUN on start; no other transitions. start in RUN ignored.
//  Entering RUN (from IDLE or DONE): same edge clears scenario_count,
//   fail_count, first_fail_*, mismatch_bits, pass; done drops next cycle.
//  Accept = in_valid & in_ready; in_ready = (state==RUN), combinational.
//   in_valid while not RUN: ignored, no counter change.
//  On accept edge: scenario_count+1; mismatch_bits <= in_result^in_expected;
//   if in_result != in_expected: fail_count+1 (hold at all-ones), mismatch=1
//   next cycle only; if first_fail_index==0 capture index=scenario_count+1,
//   result, expected. Later failures never overwrite first_fail_*.
//  Latency: counters/mismatch visible 1 cycle after accept; back-to-back
//   accepts every cycle supported (full throughput, no bubbles).
//  Last accept: same edge enters DONE; done=1, busy=0, in_ready=0 next cycle;
//   pass = (fail_count_next==0), i.e. includes the final transfer.
//  Outputs hold in DONE until start or reset.
//  Width: all compares full WIDTH; no X-propagation tolerance (X != 0/1).
// TESTING
//  1 start; pairs (00,00)(FF,FF)(66,66)(0F,0F) back-to-back -> done after 4th
//    accept+1, pass=1, scenario_count=4, fail_count=0, first_fail_index=0.
//  2 pairs (00,00)(FE,FF)(66,66)(0F,1F) -> mismatch pulses after 2nd and 4th,
//    mismatch_bits=01 then 10, fail_count=2, first_fail_index=2,
//    first_fail_result=FE, first_fail_expected=FF, pass=0.
//  3 in_valid toggled 1/0 with gaps, plus in_valid=1 in IDLE before start ->
//    IDLE beats not counted; run still ends at exactly 4 accepts.
//  4 reset asserted after 2nd accept -> next cycle all outputs 0, IDLE;
//    in_ready=0 until start.
//  5 start in DONE after failing run -> counters/first_fail_* cleared, new
//    clean run gives pass=1; start pulse during RUN has no effect.
//  6 NUM_SCENARIOS=300, CNT_W=8, all failing -> run ends at 300, fail_count=FF.

Source files
------------

// File: rtl/logic_result_checker_8_bits.sv
// Result checker: accepts (result, expected) pairs over valid/ready, compares them
// bit-exactly and tallies a run of NUM_SCENARIOS transfers with first-failure capture.
module logic_result_checker_8_bits #(
    parameter int WIDTH         = 8,
    parameter int NUM_SCENARIOS = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [WIDTH-1:0] in_expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [WIDTH-1:0] mismatch_bits,
    output logic [CNT_W-1:0] scenario_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_index,
    output logic [WIDTH-1:0] first_fail_result,
    output logic [WIDTH-1:0] first_fail_expected
);

    // Handshake: a pair transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready depends only on state, so the producer may hold valid freely.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Run length is tracked separately so runs longer than the CNT_W counters still end.
    localparam int RUN_W = (NUM_SCENARIOS < 2) ? 1 : $clog2(NUM_SCENARIOS + 1);

    state_t           state, state_next;
    logic [RUN_W-1:0] run_cnt;
    logic             accept;
    logic             is_fail;
    logic             last_accept;
    logic             start_run;
    logic [CNT_W-1:0] fail_count_next;

    assign in_ready    = (state == S_RUN);
    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign accept      = in_valid & in_ready;
    assign is_fail     = (in_result != in_expected);
    assign last_accept = accept && (run_cnt == RUN_W'(NUM_SCENARIOS - 1));
    assign start_run   = start && (state != S_RUN);

    always_comb begin
        fail_count_next = fail_count;
        if (accept && is_fail && (fail_count != {CNT_W{1'b1}}))
            fail_count_next = fail_count + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_accept) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            run_cnt             <= '0;
            pass                <= 1'b0;
            mismatch            <= 1'b0;
            mismatch_bits       <= '0;
            scenario_count      <= '0;
            fail_count          <= '0;
            first_fail_index    <= '0;
            first_fail_result   <= '0;
            first_fail_expected <= '0;
        end else begin
            state    <= state_next;
            mismatch <= 1'b0;
            if (start_run) begin
                run_cnt             <= '0;
                pass                <= 1'b0;
                mismatch_bits       <= '0;
                scenario_count      <= '0;
                fail_count          <= '0;
                first_fail_index    <= '0;
                first_fail_result   <= '0;
                first_fail_expected <= '0;
            end else if (accept) begin
                run_cnt        <= run_cnt + 1'b1;
                scenario_count <= scenario_count + 1'b1;
                mismatch_bits  <= in_result ^ in_expected;
                fail_count     <= fail_count_next;
                if (is_fail) begin
                    mismatch <= 1'b1;
                    if (first_fail_index == '0) begin
                        first_fail_index    <= scenario_count + 1'b1;
                        first_fail_result   <= in_result;
                        first_fail_expected <= in_expected;
                    end
                end
                // pass reflects the final transfer too, hence the next-value compare
                if (last_accept)
                    pass <= (fail_count_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_logic_result_checker_8_bits.sv
// Bench for logic_result_checker_8_bits: a 4-scenario instance driven through
// scenario tasks with a mismatch scoreboard, plus a 300-scenario all-failing run.
module tb_logic_result_checker_8_bits;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 4-scenario instance
    logic       start = 1'b0, in_valid = 1'b0, in_ready, busy, done, pass, mismatch;
    logic [7:0] in_result = '0, in_expected = '0, mismatch_bits;
    logic [7:0] scenario_count, fail_count, first_fail_index, first_fail_result, first_fail_expected;

    // 300-scenario instance
    logic       b_start = 1'b0, b_valid = 1'b0, b_ready, b_busy, b_done, b_pass, b_mismatch;
    logic [7:0] b_result = '0, b_expected = '0, b_mismatch_bits;
    logic [7:0] b_scenario_count, b_fail_count, b_ffi, b_ffr, b_ffe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       acc_d = 1'b0;
    logic       mon_en = 1'b0;

    logic_result_checker_8_bits #(.WIDTH(8), .NUM_SCENARIOS(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_expected(in_expected), .busy(busy), .done(done),
        .pass(pass), .mismatch(mismatch), .mismatch_bits(mismatch_bits),
        .scenario_count(scenario_count), .fail_count(fail_count),
        .first_fail_index(first_fail_index), .first_fail_result(first_fail_result),
        .first_fail_expected(first_fail_expected)
    );

    logic_result_checker_8_bits #(.WIDTH(8), .NUM_SCENARIOS(300), .CNT_W(8)) dut_big (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_result(b_result), .in_expected(b_expected), .busy(b_busy), .done(b_done),
        .pass(b_pass), .mismatch(b_mismatch), .mismatch_bits(b_mismatch_bits),
        .scenario_count(b_scenario_count), .fail_count(b_fail_count),
        .first_fail_index(b_ffi), .first_fail_result(b_ffr), .first_fail_expected(b_ffe)
    );

    // Scoreboard: each accept pops its expected mismatch_bits one cycle later
    always @(posedge clk) acc_d <= !reset && in_valid && in_ready;

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (acc_d) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_underflow: accept seen with empty expected queue");
                end else begin
                    e = exp_q.pop_front();
                    if (mismatch_bits !== e) begin
                        n_fail++; $display("FAIL sb_mismatch_bits: got %h required %h", mismatch_bits, e);
                    end
                    n_checks++;
                    if (mismatch !== (e != 8'h00)) begin
                        n_fail++; $display("FAIL sb_mismatch_pulse: got %b required %b", mismatch, (e != 8'h00));
                    end
                end
            end else begin
                n_checks++;
                if (mismatch !== 1'b0) begin
                    n_fail++; $display("FAIL sb_mismatch_idle: got %b required 0", mismatch);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Present a pair after gap idle cycles and hold it until accepted (bounded)
    task automatic send(input logic [7:0] r, input logic [7:0] e, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1; in_result = r; in_expected = e;
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL send_ready: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(r ^ e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        n_checks++;
        if ({in_ready, busy, done, pass, mismatch} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000", {in_ready, busy, done, pass, mismatch});
        end
        n_checks++;
        if ({mismatch_bits, scenario_count, fail_count, first_fail_index, first_fail_result, first_fail_expected} !== 48'h0) begin
            n_fail++; $display("FAIL reset_values: got %h required 0",
                {mismatch_bits, scenario_count, fail_count, first_fail_index, first_fail_result, first_fail_expected});
        end
    endtask

    task automatic test_clean_run();
        logic [7:0] rs[4] = '{8'h00, 8'hFF, 8'h66, 8'h0F};
        pulse_start();
        n_checks++;
        if ({busy, in_ready, done} !== 3'b110) begin
            n_fail++; $display("FAIL clean_enter_run: busy/ready/done=%b required 110", {busy, in_ready, done});
        end
        for (int i = 0; i < 4; i++) begin
            send(rs[i], rs[i], 0);
            n_checks++;
            if (scenario_count !== 8'(i + 1)) begin
                n_fail++; $display("FAIL clean_count: got %0d required %0d", scenario_count, i + 1);
            end
            n_checks++;
            if (done !== (i == 3)) begin
                n_fail++; $display("FAIL clean_done_timing: after accept %0d done=%b", i + 1, done);
            end
        end
        n_checks++;
        if ({busy, in_ready, pass, fail_count, first_fail_index} !== {3'b001, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL clean_result: busy=%b ready=%b pass=%b fails=%0d ffi=%0d required 0 0 1 0 0",
                busy, in_ready, pass, fail_count, first_fail_index);
        end
    endtask

    task automatic test_fail_run();
        logic [7:0] rs[4] = '{8'h00, 8'hFE, 8'h66, 8'h0F};
        logic [7:0] es[4] = '{8'h00, 8'hFF, 8'h66, 8'h1F};
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, pass} !== 2'b11) begin
            n_fail++; $display("FAIL done_hold: done/pass=%b required 11", {done, pass});
        end
        pulse_start();
        n_checks++;
        if ({done, busy, pass, scenario_count} !== {3'b010, 8'h00}) begin
            n_fail++; $display("FAIL restart_clear: done=%b busy=%b pass=%b count=%0d required 0 1 0 0", done, busy, pass, scenario_count);
        end
        for (int i = 0; i < 4; i++) send(rs[i], es[i], 0);
        n_checks++;
        if ({done, pass, fail_count, first_fail_index, first_fail_result, first_fail_expected} !== {2'b10, 8'd2, 8'd2, 8'hFE, 8'hFF}) begin
            n_fail++; $display("FAIL fail_result: done=%b pass=%b fails=%0d ffi=%0d ffr=%h ffe=%h required 1 0 2 2 fe ff",
                done, pass, fail_count, first_fail_index, first_fail_result, first_fail_expected);
        end
    endtask

    // start from DONE of a failing run, then a start pulse mid-run must be ignored
    task automatic test_restart();
        pulse_start();
        n_checks++;
        if ({fail_count, first_fail_index, first_fail_result, first_fail_expected, mismatch_bits} !== 40'h0) begin
            n_fail++; $display("FAIL restart_first_fail: fails=%h ffi=%h ffr=%h ffe=%h bits=%h required 0",
                fail_count, first_fail_index, first_fail_result, first_fail_expected, mismatch_bits);
        end
        send(8'h3C, 8'h3C, 0);
        send(8'hA5, 8'hA5, 1);
        pulse_start();
        n_checks++;
        if ({busy, scenario_count} !== {1'b1, 8'd2}) begin
            n_fail++; $display("FAIL start_in_run: busy=%b count=%0d required 1 2", busy, scenario_count);
        end
        send(8'h5A, 8'h5A, 0);
        send(8'hC3, 8'hC3, 0);
        n_checks++;
        if ({done, pass, scenario_count} !== {2'b11, 8'd4}) begin
            n_fail++; $display("FAIL restart_clean: done=%b pass=%b count=%0d required 1 1 4", done, pass, scenario_count);
        end
    endtask

    task automatic test_idle_and_gaps();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        in_valid = 1'b1; in_result = 8'h12; in_expected = 8'h34;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, scenario_count, fail_count} !== 17'h0) begin
            n_fail++; $display("FAIL idle_valid_ignored: ready=%b count=%0d fails=%0d required 0", in_ready, scenario_count, fail_count);
        end
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            send(r, (i == 2) ? ~r : r, $urandom_range(1, 3));
        end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({done, pass, scenario_count, fail_count, first_fail_index} !== {2'b10, 8'd4, 8'd1, 8'd3}) begin
            n_fail++; $display("FAIL gaps_result: done=%b pass=%b count=%0d fails=%0d ffi=%0d required 1 0 4 1 3",
                done, pass, scenario_count, fail_count, first_fail_index);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        send(8'h11, 8'h11, 0);
        send(8'h22, 8'h20, 0);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_checks++;
        if ({in_ready, busy, done, pass, mismatch, mismatch_bits, scenario_count, fail_count, first_fail_index,
             first_fail_result, first_fail_expected} !== 53'h0) begin
            n_fail++; $display("FAIL reset_mid_run: ready=%b busy=%b count=%0d fails=%0d ffi=%0d bits=%h required all 0",
                in_ready, busy, scenario_count, fail_count, first_fail_index, mismatch_bits);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_stays_idle: in_ready=%b required 0", in_ready);
        end
    endtask

    task automatic test_long_run();
        int acc = 0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        b_valid = 1'b1; b_result = 8'h00; b_expected = 8'hFF;
        for (int c = 0; c < 400 && !b_done; c++) begin
            if (b_ready) acc++;
            @(negedge clk);
            b_result = 8'(acc); b_expected = ~8'(acc);
        end
        b_valid = 1'b0;
        n_checks++;
        if ({b_done, b_pass} !== 2'b10 || acc != 300) begin
            n_fail++; $display("FAIL long_run_end: done=%b pass=%b accepts=%0d required 1 0 300", b_done, b_pass, acc);
        end
        n_checks++;
        if ({b_fail_count, b_scenario_count, b_ffi, b_ffr, b_ffe, b_mismatch_bits} !== {8'hFF, 8'h2C, 8'h01, 8'h00, 8'hFF, 8'hFF}) begin
            n_fail++; $display("FAIL long_run_counts: fails=%h count=%h ffi=%h ffr=%h ffe=%h bits=%h required ff 2c 01 00 ff ff",
                b_fail_count, b_scenario_count, b_ffi, b_ffr, b_ffe, b_mismatch_bits);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fail_run();
        test_restart();
        test_idle_and_gaps();
        test_reset_mid_run();
        test_long_run();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d entries remain required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
